// File: rtl/crc16_frame_ctrl.sv
// crc16_frame_ctrl
// Length-bounded frame sequencer for a bit-serial CRC-16 (poly 0x8005, init 0,
// MSB first, no reflection, no final XOR). Payload bits pass straight through
// from the source to the sink. The 16 CRC bits are then appended to the same
// stream. A low out_ready stalls everything.

module crc16_frame_ctrl #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic             out_crc,
  output logic             out_last,
  output logic [15:0]      crc_value,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] remainCount_q;
  logic [15:0]      crc_q;
  logic [15:0]      crc_d;
  logic [15:0]      shift_q;
  logic [3:0]       crcIdx_q;
  logic [15:0]      crcValue_q;
  logic             done_q;
  logic             dataXfer;
  logic             crcFeedback;

  // Next CRC value if the current payload bit is consumed this cycle
  always_comb begin
    crcFeedback = crc_q[15] ^ in_bit;
    crc_d       = {crc_q[14:0], 1'b0} ^ (crcFeedback ? 16'h8005 : 16'h0000);
    dataXfer    = (state_q == DATA) && in_valid && out_ready;
  end

  // Stream steering: pass-through in DATA, shift-register drive in CRC, quiet in IDLE
  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_crc   = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      DATA: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_bit   = in_bit;
      end
      CRC: begin
        out_valid = 1'b1;
        out_crc   = 1'b1;
        out_bit   = shift_q[15];
        out_last  = (crcIdx_q == 4'd15);
      end
      default: begin
      end
    endcase
  end

  // Frame FSM with its counters, CRC accumulator and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      remainCount_q <= '0;
      crc_q         <= 16'h0000;
      shift_q       <= 16'h0000;
      crcIdx_q      <= 4'd0;
      crcValue_q    <= 16'h0000;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (frame_len != '0)) begin
            remainCount_q <= frame_len;
            crc_q         <= 16'h0000;
            state_q       <= DATA;
          end
        end
        DATA: begin
          if (dataXfer) begin
            crc_q         <= crc_d;
            remainCount_q <= remainCount_q - LEN_W'(1);
            if (remainCount_q == LEN_W'(1)) begin
              crcValue_q <= crc_d;
              shift_q    <= crc_d;
              crcIdx_q   <= 4'd0;
              state_q    <= CRC;
            end
          end
        end
        CRC: begin
          if (out_ready) begin
            shift_q  <= {shift_q[14:0], 1'b0};
            crcIdx_q <= crcIdx_q + 4'd1;
            if (crcIdx_q == 4'd15) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign crc_value = crcValue_q;
  assign done      = done_q;

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Directed testbench for crc16_frame_ctrl using immediate assertions.
// Expected CRCs are hand-computed CRC-16/BUYPASS values.

module tb_crc16_frame_ctrl;

  localparam int LEN_W = 12;

  logic             clk;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             busy;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_bit;
  logic             out_ready;
  logic             out_crc;
  logic             out_last;
  logic [15:0]      crc_value;
  logic             done;

  int checks;
  int failures;

  crc16_frame_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_ready (out_ready),
    .out_crc   (out_crc),
    .out_last  (out_last),
    .crc_value (crc_value),
    .done      (done)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-bit comparison
  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Multi-bit comparison
  task automatic checkOutputWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All outputs at their idle/reset values
  task automatic checkResetOutputs();
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstInReady", in_ready, 1'b0);
    checkOutput("rstOutValid", out_valid, 1'b0);
    checkOutput("rstOutBit", out_bit, 1'b0);
    checkOutput("rstOutCrc", out_crc, 1'b0);
    checkOutput("rstOutLast", out_last, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutputWord("rstCrcValue", 32'(crc_value), 32'h0);
  endtask

  // Runs one frame from the current (IDLE) cycle; payload bit i is payload[len-1-i]
  task automatic applyStimulus(input logic [71:0] payload, input int len,
                               input logic [15:0] expCrc, input bit stalls,
                               input bit midStart);
    int sent;
    int crcIdx;
    int cyc;
    start     = 1'b1;
    frame_len = LEN_W'(len);
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("startBusy", busy, 1'b0);
    checkOutput("startInReady", in_ready, 1'b0);
    @(posedge clk); #1;
    start     = 1'b0;
    frame_len = '0;
    #1;
    checkOutput("busyAfterStart", busy, 1'b1);
    sent   = 0;
    crcIdx = 0;
    cyc    = 1;
    while (crcIdx < 16 && cyc < 4000) begin
      in_valid  = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bit    = (sent < len) ? payload[len-1-sent] : 1'b0;
      if (midStart && sent == 3) begin
        start     = 1'b1;
        frame_len = LEN_W'(5);
      end else begin
        start     = 1'b0;
        frame_len = '0;
      end
      #1;
      if (sent < len) begin
        checkOutput("dataOutValid", out_valid, in_valid);
        checkOutput("dataOutBit", out_bit, in_bit);
        checkOutput("dataInReady", in_ready, out_ready);
        checkOutput("dataOutCrc", out_crc, 1'b0);
        if (in_valid && out_ready) sent++;
      end else begin
        checkOutput("crcInReady", in_ready, 1'b0);
        checkOutput("crcOutValid", out_valid, 1'b1);
        checkOutput("crcOutCrc", out_crc, 1'b1);
        checkOutput("crcOutBit", out_bit, expCrc[15-crcIdx]);
        checkOutput("crcOutLast", out_last, crcIdx == 15);
        if (out_ready) crcIdx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    frame_len = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutputWord("crcBitsSeen", 32'(crcIdx), 32'd16);
    checkOutput("doneFlag", done, 1'b1);
    checkOutput("doneBusy", busy, 1'b0);
    checkOutput("doneOutValid", out_valid, 1'b0);
    checkOutputWord("crcValue", 32'(crc_value), 32'(expCrc));
    if (!stalls) checkOutputWord("doneCycle", 32'(cyc), 32'(len + 17));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    frame_len = '0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs();
    reset = 1'b0;
    @(posedge clk); #1;
    checkResetOutputs();

    $display("[TB] 1-bit frame, bit 1");
    applyStimulus(72'h1, 1, 16'h8005, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("doneOnePulse", done, 1'b0);

    $display("[TB] 2-bit frame 1,0 then 1-bit frame 0");
    applyStimulus(72'h2, 2, 16'h800F, 1'b0, 1'b0);
    applyStimulus(72'h0, 1, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;

    $display("[TB] zero-length start");
    start     = 1'b1;
    frame_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("zeroLenBusy", busy, 1'b0);
    checkOutput("zeroLenDone", done, 1'b0);
    @(posedge clk); #1;
    checkOutput("zeroLenBusy2", busy, 1'b0);
    checkOutput("zeroLenDone2", done, 1'b0);

    $display("[TB] 123456789 with random gaps and stalls");
    applyStimulus(72'h313233343536373839, 72, 16'hFEE8, 1'b1, 1'b0);
    @(posedge clk); #1;

    $display("[TB] reset during 5th CRC bit");
    start     = 1'b1;
    frame_len = LEN_W'(1);
    @(posedge clk); #1;
    start     = 1'b0;
    frame_len = '0;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midCrcOutCrc", out_crc, 1'b1);
    checkOutput("midCrcOutBit", out_bit, 1'b0);
    checkOutputWord("midCrcValue", 32'(crc_value), 32'h8005);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkResetOutputs();
    applyStimulus(72'h1, 1, 16'h8005, 1'b0, 1'b0);

    $display("[TB] mid-frame start ignored, then back-to-back frame");
    @(posedge clk); #1;
    applyStimulus(72'h313233343536373839, 72, 16'hFEE8, 1'b0, 1'b1);
    applyStimulus(72'h2, 2, 16'h800F, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("finalDoneLow", done, 1'b0);
    checkOutput("finalBusyLow", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
